// File: rtl/wb_arb_pkg.sv
// Shared constants and types for the writeback bus arbiter.
// Imported by the picker, the mux wrapper and the arbiter top.
package wb_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 16;
    localparam int SEL_W   = 3;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } wb_arb_state_t;

    localparam logic [SEL_W-1:0] SEL_IN0 = 3'b000;
    localparam logic [SEL_W-1:0] SEL_IN1 = 3'b001;
    localparam logic [SEL_W-1:0] SEL_IN2 = 3'b010;
    localparam logic [SEL_W-1:0] SEL_IN3 = 3'b011;

endpackage

// File: rtl/mux4to1_16bit.sv
// Existing 4:1 16-bit word mux with a 3-bit select.
// Unused select codes return zero.
module mux4to1_16bit
    import wb_arb_pkg::*;
(
    input  logic [SEL_W-1:0] sel,
    input  logic [15:0]      in0,
    input  logic [15:0]      in1,
    input  logic [15:0]      in2,
    input  logic [15:0]      in3,
    output logic [15:0]      out
);

    always_comb begin
        out = '0;
        case (sel)
            SEL_IN0: out = in0;
            SEL_IN1: out = in1;
            SEL_IN2: out = in2;
            SEL_IN3: out = in3;
            default: out = '0;
        endcase
    end

endmodule

// File: rtl/rr_pick4.sv
// Combinational 4-way round-robin picker.
// Searches req starting at ptr, wrapping 3 -> 0.
module rr_pick4
    import wb_arb_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       any,
    output logic [1:0] winner,
    output logic [3:0] onehot
);

    logic [1:0] idx;

    always_comb begin
        any    = 1'b0;
        winner = 2'd0;
        idx    = 2'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = ptr + 2'(i);
            if (!any && req[idx]) begin
                any    = 1'b1;
                winner = idx;
            end
        end
        onehot = any ? (4'b0001 << winner) : 4'b0000;
    end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Round-robin arbiter and output register for the writeback bus.
// Grants one of four sources per cycle into a valid/ready output.
module wb_bus_arbiter
    import wb_arb_pkg::*;
#(
    parameter int DATA_W  = wb_arb_pkg::DATA_W,
    parameter int NUM_REQ = wb_arb_pkg::NUM_REQ
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        req,
    input  logic [DATA_W-1:0] in0,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    input  logic [DATA_W-1:0] in3,
    output logic [3:0]        gnt,
    output logic [SEL_W-1:0]  sel,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    wb_arb_state_t state;
    logic [1:0]    ptr;
    logic          any;
    logic [1:0]    winner;
    logic [3:0]    onehot;
    logic          load;
    logic [15:0]   mux_out;

    rr_pick4 u_pick (
        .req    (req),
        .ptr    (ptr),
        .any    (any),
        .winner (winner),
        .onehot (onehot)
    );

    mux4to1_16bit u_mux (
        .sel (sel),
        .in0 (in0),
        .in1 (in1),
        .in2 (in2),
        .in3 (in3),
        .out (mux_out)
    );

    // Reset suppresses load so no grant escapes in the reset cycle.
    assign load = !reset && any && (state == IDLE || out_ready);
    assign gnt  = load ? onehot : 4'b0000;
    assign sel  = load ? {1'b0, winner} : SEL_IN0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            state     <= HOLD;
            ptr       <= winner + 2'd1;
            out_data  <= mux_out;
            out_valid <= 1'b1;
        end else if (state == HOLD && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed vector bench for wb_bus_arbiter.
// Each row is one cycle: inputs plus expected pre-edge outputs.
module tb_wb_bus_arbiter;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic        rdy;
        logic [15:0] d0;
        logic [3:0]  gnt;
        logic [2:0]  sel;
        logic        vld;
        logic [15:0] dat;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] in0, in1, in2, in3;
    logic [3:0]  gnt;
    logic [2:0]  sel;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;

    int nvec = 0;
    int nmis = 0;
    vec_t tv[$];

    always #5 clk = ~clk;

    wb_bus_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .in0       (in0),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .gnt       (gnt),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    function automatic vec_t mk(logic r, logic [3:0] q, logic y,
                                logic [15:0] d, logic [3:0] g,
                                logic [2:0] s, logic v,
                                logic [15:0] o);
        vec_t t;
        t.rst = r; t.req = q; t.rdy = y; t.d0 = d;
        t.gnt = g; t.sel = s; t.vld = v; t.dat = o;
        return t;
    endfunction

    task automatic chk(string name, int row, logic [15:0] act,
                       logic [15:0] exp);
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s row %0d: got %h want %h",
                     name, row, act, exp);
        end
    endtask

    initial begin
        // idle after reset
        tv.push_back(mk(1, 4'b0001, 0, 16'hA5A5, 4'b0000, 0, 0, 16'h0000));
        tv.push_back(mk(0, 4'b0001, 0, 16'hA5A5, 4'b0001, 0, 0, 16'h0000));
        tv.push_back(mk(0, 4'b0000, 1, 16'hA5A5, 4'b0000, 0, 1, 16'hA5A5));
        tv.push_back(mk(0, 4'b0000, 0, 16'hA5A5, 4'b0000, 0, 0, 16'hA5A5));
        tv.push_back(mk(0, 4'b0011, 0, 16'h1000, 4'b0010, 1, 0, 16'hA5A5));
        tv.push_back(mk(0, 4'b0000, 1, 16'h1000, 4'b0000, 0, 1, 16'h1001));
        tv.push_back(mk(1, 4'b1111, 1, 16'h1000, 4'b0000, 0, 0, 16'h1001));
        // continuous round robin
        tv.push_back(mk(0, 4'b1111, 1, 16'h1000, 4'b0001, 0, 0, 16'h0000));
        tv.push_back(mk(0, 4'b1111, 1, 16'h1000, 4'b0010, 1, 1, 16'h1000));
        tv.push_back(mk(0, 4'b1111, 1, 16'h1000, 4'b0100, 2, 1, 16'h1001));
        tv.push_back(mk(0, 4'b1111, 1, 16'h1000, 4'b1000, 3, 1, 16'h1002));
        tv.push_back(mk(0, 4'b1111, 1, 16'h1000, 4'b0001, 0, 1, 16'h1003));
        tv.push_back(mk(0, 4'b1111, 1, 16'h1000, 4'b0010, 1, 1, 16'h1000));
        // stall, then release to source 2
        for (int i = 0; i < 3; i++)
            tv.push_back(mk(0, 4'b0110, 0, 16'h1000, 4'b0000, 0, 1, 16'h1001));
        tv.push_back(mk(0, 4'b0110, 1, 16'h1000, 4'b0100, 2, 1, 16'h1001));
        tv.push_back(mk(0, 4'b0000, 1, 16'h1000, 4'b0000, 0, 1, 16'h1002));
        tv.push_back(mk(0, 4'b0000, 0, 16'h1000, 4'b0000, 0, 0, 16'h1002));
        // reset with a pending word and ptr = 3
        tv.push_back(mk(0, 4'b0100, 0, 16'h1000, 4'b0100, 2, 0, 16'h1002));
        tv.push_back(mk(1, 4'b1001, 1, 16'h1000, 4'b0000, 0, 1, 16'h1002));
        tv.push_back(mk(0, 4'b1001, 0, 16'h1000, 4'b0001, 0, 0, 16'h0000));
        // req[2] raised and dropped during a stall
        tv.push_back(mk(0, 4'b0100, 0, 16'h1000, 4'b0000, 0, 1, 16'h1000));
        tv.push_back(mk(0, 4'b0100, 0, 16'h1000, 4'b0000, 0, 1, 16'h1000));
        tv.push_back(mk(0, 4'b0000, 0, 16'h1000, 4'b0000, 0, 1, 16'h1000));
        tv.push_back(mk(0, 4'b0000, 1, 16'h1000, 4'b0000, 0, 1, 16'h1000));
        tv.push_back(mk(0, 4'b0000, 0, 16'h1000, 4'b0000, 0, 0, 16'h1000));

        reset = 1'b1; req = '0; out_ready = 1'b0;
        in0 = 16'h1000; in1 = 16'h1001;
        in2 = 16'h1002; in3 = 16'h1003;
        repeat (2) @(negedge clk);

        foreach (tv[i]) begin
            @(negedge clk);
            reset = tv[i].rst; req = tv[i].req;
            out_ready = tv[i].rdy; in0 = tv[i].d0;
            #1;
            nvec++;
            chk("gnt", i, 16'(gnt), 16'(tv[i].gnt));
            chk("sel", i, 16'(sel), 16'(tv[i].sel));
            chk("out_valid", i, 16'(out_valid), 16'(tv[i].vld));
            chk("out_data", i, out_data, tv[i].dat);
        end

        // out_ready has no effect in IDLE
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            req = 4'b0000; out_ready = 1'b1;
            #1;
            nvec++;
            chk("idle_rdy_valid", i, 16'(out_valid), 16'd0);
            chk("idle_rdy_gnt", i, 16'(gnt), 16'd0);
        end

        // ptr = 1: source 0 must win within 4 loads
        begin
            bit got;
            got = 1'b0;
            for (int i = 0; i < 4 && !got; i++) begin
                @(negedge clk);
                req = 4'b1111; out_ready = 1'b1;
                #1;
                if (gnt[0]) begin
                    got = 1'b1;
                    nvec++;
                    chk("fair_cycle", i, 16'(i), 16'd3);
                end
            end
            if (!got) begin
                nvec++;
                nmis++;
                $display("FAIL fair_timeout: got no gnt[0] want gnt[0] in 4 cycles");
            end
            @(negedge clk);
            req = 4'b0000;
            #1;
            nvec++;
            chk("fair_data", 0, out_data, 16'h1000);
            chk("fair_valid", 0, 16'(out_valid), 16'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/wb_bus_arbiter.md
# wb_bus_arbiter

Round-robin arbiter and sequencer for the shared 16-bit writeback bus. It accepts single-beat writeback requests from four sources and selects one per cycle through the existing 4:1 16-bit mux (`mux4to1_16bit`). It captures the winning word in an output register and presents it to the register-file write port with a valid/ready handshake. It drives the mux select and the one-hot grants, and it sits between the execution units and the register-file write stage.

## Interface
- `DATA_W`, 16, width of each request word and of the output word
- `NUM_REQ`, 4, number of requesters; fixed at 4 because the select is 2-bit-coded onto the mux's 3-bit select
- `clk`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `req`  in  4  request per source; held high with stable data until granted
- `in0`..`in3`  in  16 each  request words
- `gnt`  out  4  one-hot, combinational; high in the cycle the source's word is captured
- `sel`  out  3  mux select; 3'b000..3'b011; bit 2 is always 0
- `out_data`  out  16  registered winning word
- `out_valid`  out  1  `out_data` holds an unconsumed word
- `out_ready`  in  1  sink accepts `out_data` this cycle

## Operation
- The FSM has two states:
  - IDLE: `out_valid` = 0.
  - HOLD: `out_valid` = 1; `out_data` is frozen until accepted.
- Define `load` = (IDLE or (HOLD and `out_ready`)) and |`req`.
- Round-robin pick: search `req` starting at pointer `ptr` (2-bit), in order ptr, ptr+1, ... with wrap 3 to 0. The first set bit is the winner `w`.
- When `load` is high:
  - `gnt[w]` = 1 and `sel` = {1'b0, w}.
  - At the edge, `out_data` <= mux output, state goes to HOLD, and `ptr` <= w+1 (mod 4).
- When HOLD and `out_ready` are high but no `req` is set: state goes to IDLE and `out_data` keeps its last value.
- When HOLD is high and `out_ready` is low: no grant, `gnt` = 0, and `out_data`/`ptr` hold.
- When `load` is low: `sel` = 3'b000 and `gnt` = 4'b0000.
- Sources may drop `req` before being granted. A dropped request is never granted.
- `out_ready` is ignored in IDLE.
- Fairness: a source holding `req` is granted within 4 loads.

## Timing
- Reset values: state IDLE, `ptr` = 0, `out_data` = 16'h0000, `out_valid` = 0.
- Combinational outputs `gnt` and `sel` are 0 during reset because `load` is forced low.
- Latency: a `req` seen with `load` high in cycle N produces `gnt` in cycle N and `out_valid` with the data in cycle N+1.
- Throughput: back-to-back with no bubble. With `out_ready` held high, one word transfers per cycle.
- A simultaneous accept and new grant (HOLD, `out_ready` = 1, `req` ≠ 0) replaces `out_data` in the same edge, and `out_valid` stays 1.
- Reset asserted mid-transfer: the pending word is discarded, and `out_valid` = 0 and `ptr` = 0 after the edge. A `gnt` seen in the reset cycle is not issued.
- Pointer wrap: after a winner of 3, `ptr` = 0.

## Structure
- A shared package `wb_arb_pkg` holds:
  - `NUM_REQ` = 4, `DATA_W` = 16 and `SEL_W` = 3;
  - the state enum `wb_arb_state_t` {IDLE, HOLD};
  - the select constants `SEL_IN0`..`SEL_IN3`.
- Sub-module `rr_pick4`: a combinational round-robin picker with inputs `req[3:0]` and `ptr[1:0]`, and outputs `any`, `winner[1:0]` and `onehot[3:0]`.
- The datapath instantiates the existing `mux4to1_16bit`, driven by `sel`.

## Test plan
- Reset, then `req` = 4'b0001 with `in0` = 16'hA5A5:
  - cycle 0: `gnt` = 0001 and `sel` = 000;
  - cycle 1: `out_valid` = 1 and `out_data` = A5A5;
  - `ptr` = 1.
- All four sources request continuously with `out_ready` = 1 and `in0..in3` = 16'h1000..16'h1003 → grant order 0,1,2,3,0, and `out_data` = 1000,1001,1002,1003,1000 on consecutive cycles.
- `out_ready` held low for 3 cycles while `req` = 4'b0110 → `out_data` is frozen and `gnt` = 0 during the stall. On release, the next grant goes to source 2 (ptr advanced past 1).
- Last word accepted with `req` = 0 → `out_valid` falls the next cycle, state is IDLE, and `out_data` is unchanged.
- Reset pulsed while `out_valid` = 1 with `ptr` = 3 → the next cycle shows `out_valid` = 0, and the next `req` = 4'b1001 grants source 0.
- `req[2]` raised and dropped before grant (`out_ready` = 0 throughout) → source 2 is never granted, and no spurious `out_data` update occurs.
